// File: rtl/sram_burst_io_ctrl.sv
// sram_burst_io_ctrl
//   Serial host interface to a synchronous single-port SRAM macro. The host shifts an
//   {address, data} frame (or the data field alone) into reg_bits LSB first, then commands
//   single read or write cycles through a BGN/RDY handshake. The address can post-increment
//   after each access, and the SRAM read latency is configurable.
//
// Optional build macro: SRAM_IO_PARITY_EN
//   Frame shifts (mode 00) carry one extra trailing even-parity bit, a mismatch raises
//   o_perr, and a write launched while o_perr is set performs no SRAM cycle.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_bgn      operation request (level), held until o_rdy is seen
//   i_load_n   active-low launch strobe, qualified by i_bgn
//   i_ctrl     00 frame shift, 01 SRAM read, 10 data-only shift, 11 SRAM write
//   i_auto_inc post-increment the address after a read/write
//   i_si       serial data in, LSB first
//   i_pi       SRAM read data
//   o_rdy      operation complete
//   o_so       serial data out (reg_bits[0])
//   o_d_we     SRAM write enable, active low
//   o_cen      SRAM chip enable, active low
//   o_a        SRAM address (upper field of reg_bits)
//   o_po       SRAM write data (lower field of reg_bits)
//   o_perr     parity error flag (SRAM_IO_PARITY_EN builds only)
module sram_burst_io_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned REG_BITS_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_bgn,
  input  logic                  i_load_n,
  input  logic [1:0]            i_ctrl,
  input  logic                  i_auto_inc,
  input  logic                  i_si,
  input  logic [DATA_WIDTH-1:0] i_pi,
  output logic                  o_rdy,
  output logic                  o_so,
  output logic                  o_d_we,
  output logic                  o_cen,
  output logic [ADDR_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_po
`ifdef SRAM_IO_PARITY_EN
  ,
  output logic                  o_perr
`endif
);

`ifdef SRAM_IO_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned CNT_W = $clog2(REG_BITS_WIDTH + 2);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(REG_BITS_WIDTH + PAR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  =
      CNT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

  localparam logic [1:0] MODE_FRAME = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StShift, StRdEn, StRdWait, StCap, StWr, StDone
  } state_e;

  state_e                    r_state, w_state_next;
  logic [REG_BITS_WIDTH-1:0] r_bits, w_bits_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic [1:0]                r_mode, w_mode_next;
  logic                      r_inc, w_inc_next;
  logic                      w_shift_last;
  logic                      w_frame_bit;
  logic                      w_bump;
`ifdef SRAM_IO_PARITY_EN
  logic                      r_par, w_par_next;
  logic                      r_perr, w_perr_next;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_FRAME;
      r_inc   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bits  <= w_bits_next;
      r_cnt   <= w_cnt_next;
      r_mode  <= w_mode_next;
      r_inc   <= w_inc_next;
    end
  end

`ifdef SRAM_IO_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_par  <= w_par_next;
      r_perr <= w_perr_next;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_bits_next  = r_bits;
    w_cnt_next   = r_cnt;
    w_mode_next  = r_mode;
    w_inc_next   = r_inc;
    w_bump       = 1'b0;
`ifdef SRAM_IO_PARITY_EN
    w_par_next   = r_par;
    w_perr_next  = r_perr;
`endif
    w_shift_last = (r_mode == MODE_FRAME) ? (r_cnt == FRAME_LAST) : (r_cnt == DATA_LAST);
    // The trailing parity bit of a frame is checked, not stored.
    w_frame_bit  = !((PAR_BITS != 0) && w_shift_last);

    unique case (r_state)
      StIdle: begin
        if (i_bgn && !i_load_n) begin
          w_mode_next = i_ctrl;
          w_inc_next  = i_auto_inc;
          w_cnt_next  = '0;
`ifdef SRAM_IO_PARITY_EN
          w_par_next  = 1'b0;
          w_perr_next = 1'b0;
`endif
          unique case (i_ctrl)
            MODE_READ:  w_state_next = StRdEn;
`ifdef SRAM_IO_PARITY_EN
            // A write carrying a known-bad frame is suppressed entirely.
            MODE_WRITE: w_state_next = r_perr ? StDone : StWr;
`else
            MODE_WRITE: w_state_next = StWr;
`endif
            default:    w_state_next = StShift;
          endcase
        end
      end
      StShift: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_mode == MODE_FRAME) begin
          if (w_frame_bit) begin
            w_bits_next = {i_si, r_bits[REG_BITS_WIDTH-1:1]};
          end
`ifdef SRAM_IO_PARITY_EN
          w_par_next = r_par ^ i_si;
          if (w_shift_last) begin
            w_perr_next = r_par ^ i_si;
          end
`endif
        end else begin
          w_bits_next[DATA_WIDTH-1:0] = {i_si, r_bits[DATA_WIDTH-1:1]};
        end
        if (w_shift_last) begin
          w_state_next = StDone;
        end
      end
      StRdEn: begin
        w_cnt_next   = '0;
        w_state_next = (READ_LATENCY > 1) ? StRdWait : StCap;
      end
      StRdWait: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == WAIT_LAST) begin
          w_state_next = StCap;
        end
      end
      StCap: begin
        // Read data is valid here, READ_LATENCY edges after the SRAM sampled CEN low.
        w_bits_next[DATA_WIDTH-1:0] = i_pi;
        w_bump       = 1'b1;
        w_state_next = StDone;
      end
      StWr: begin
        w_bump       = 1'b1;
        w_state_next = StDone;
      end
      StDone: begin
        if (!i_bgn) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Post-increment wraps naturally at 2^ADDR_WIDTH.
    if (w_bump && r_inc) begin
      w_bits_next[REG_BITS_WIDTH-1:DATA_WIDTH] =
          r_bits[REG_BITS_WIDTH-1:DATA_WIDTH] + ADDR_WIDTH'(1);
    end
  end

  assign o_rdy  = (r_state == StDone);
  assign o_so   = r_bits[0];
  assign o_cen  = !((r_state == StRdEn) || (r_state == StWr));
  assign o_d_we = !(r_state == StWr);
  assign o_a    = r_bits[REG_BITS_WIDTH-1:DATA_WIDTH];
  assign o_po   = r_bits[DATA_WIDTH-1:0];
`ifdef SRAM_IO_PARITY_EN
  assign o_perr = r_perr;
`endif

endmodule

// File: tb/tb_sram_burst_io_ctrl.sv
module tb_sram_burst_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bgn = 1'b0;
  logic       bgn3 = 1'b0;
  logic       load_n = 1'b1;
  logic [1:0] ctrl = 2'b00;
  logic       auto_inc = 1'b0;
  logic       si = 1'b0;
  logic [7:0] pi = 8'h00;
  logic [7:0] pi3 = 8'h00;
  logic       rdy, so, d_we, cen;
  logic [8:0] a;
  logic [7:0] po;
  logic       rdy3, so3, d_we3, cen3;
  logic [8:0] a3;
  logic [7:0] po3;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [512];

  always #5 clk = ~clk;

  sram_burst_io_ctrl u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bgn      (bgn),
    .i_load_n   (load_n),
    .i_ctrl     (ctrl),
    .i_auto_inc (auto_inc),
    .i_si       (si),
    .i_pi       (pi),
    .o_rdy      (rdy),
    .o_so       (so),
    .o_d_we     (d_we),
    .o_cen      (cen),
    .o_a        (a),
    .o_po       (po)
  );

  sram_burst_io_ctrl #(
    .READ_LATENCY (3)
  ) u_dut3 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bgn      (bgn3),
    .i_load_n   (load_n),
    .i_ctrl     (ctrl),
    .i_auto_inc (auto_inc),
    .i_si       (si),
    .i_pi       (pi3),
    .o_rdy      (rdy3),
    .o_so       (so3),
    .o_d_we     (d_we3),
    .o_cen      (cen3),
    .o_a        (a3),
    .o_po       (po3)
  );

  // SRAM model, latency 1: data for a read enable sampled at edge k is valid after edge k.
  always @(posedge clk) begin
    if (!cen && !d_we) mem[a] <= po;
    if (!cen && d_we) pi <= mem[a];
  end

  // Latency-3 instance sees a value that changes every cycle.
  always @(posedge clk) pi3 <= pi3 + 8'd1;

  typedef struct {
    logic [1:0]  ctrl;
    logic        inc;
    logic [16:0] frame;
    logic [8:0]  exp_a;
    logic [7:0]  exp_po;
    int          exp_cen;
    int          exp_we;
    logic [8:0]  exp_wa;
    logic        chk_so;
    logic [7:0]  exp_so;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [1:0] c, input logic inc, input logic [16:0] fr,
                              input logic [8:0] ea, input logic [7:0] epo, input int ecen,
                              input int ewe, input logic [8:0] wa, input logic cso,
                              input logic [7:0] eso);
    vec_t v;
    v.ctrl = c; v.inc = inc; v.frame = fr; v.exp_a = ea; v.exp_po = epo;
    v.exp_cen = ecen; v.exp_we = ewe; v.exp_wa = wa; v.chk_so = cso; v.exp_so = eso;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int         nbits;
    int         cen_n;
    int         we_n;
    logic [8:0] wa;
    logic [7:0] wd;
    logic [7:0] sow;
    nbits = (v.ctrl == 2'b00) ? 17 : ((v.ctrl == 2'b10) ? 8 : 0);
    cen_n = 0; we_n = 0; wa = '0; wd = '0; sow = '0;
    @(negedge clk);
    ctrl = v.ctrl; auto_inc = v.inc; bgn = 1'b1; load_n = 1'b0;
    @(negedge clk);
    // Post-launch changes to CTRL/AUTO_INC must be ignored.
    load_n = 1'b1; ctrl = ~v.ctrl; auto_inc = ~v.inc;
    for (int k = 0; k < nbits + 8 && !rdy; k++) begin
      if (k < 8 && k < nbits) sow[k] = so;
      if (k < nbits) si = v.frame[k];
      if (!cen) cen_n++;
      if (!d_we) begin we_n++; wa = a; wd = po; end
      @(negedge clk);
    end
    check($sformatf("v%0d_rdy", idx), rdy, 1'b1);
    check($sformatf("v%0d_a", idx), a, v.exp_a);
    check($sformatf("v%0d_po", idx), po, v.exp_po);
    check($sformatf("v%0d_cen_cycles", idx), cen_n, v.exp_cen);
    check($sformatf("v%0d_we_cycles", idx), we_n, v.exp_we);
    if (v.exp_we != 0) begin
      check($sformatf("v%0d_wr_addr", idx), wa, v.exp_wa);
      check($sformatf("v%0d_wr_data", idx), wd, v.exp_po);
    end
    if (v.chk_so) check($sformatf("v%0d_so", idx), sow, v.exp_so);
    bgn = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_rdy_drop", idx), rdy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int acc;
    logic [7:0] p;
    vec_t v;

    vecs[0]  = mk(2'b00, 1'b0, {9'h020, 8'h3C}, 9'h020, 8'h3C, 0, 0, 9'h000, 1'b1, 8'h00);
    vecs[1]  = mk(2'b11, 1'b0, 17'h0,           9'h020, 8'h3C, 1, 1, 9'h020, 1'b0, 8'h00);
    vecs[2]  = mk(2'b00, 1'b0, {9'h020, 8'h00}, 9'h020, 8'h00, 0, 0, 9'h000, 1'b1, 8'h3C);
    vecs[3]  = mk(2'b01, 1'b0, 17'h0,           9'h020, 8'h3C, 1, 0, 9'h000, 1'b0, 8'h00);
    vecs[4]  = mk(2'b00, 1'b0, {9'h010, 8'h00}, 9'h010, 8'h00, 0, 0, 9'h000, 1'b1, 8'h3C);
    vecs[5]  = mk(2'b10, 1'b0, {9'h000, 8'h11}, 9'h010, 8'h11, 0, 0, 9'h000, 1'b1, 8'h00);
    vecs[6]  = mk(2'b11, 1'b1, 17'h0,           9'h011, 8'h11, 1, 1, 9'h010, 1'b0, 8'h00);
    vecs[7]  = mk(2'b10, 1'b0, {9'h000, 8'h22}, 9'h011, 8'h22, 0, 0, 9'h000, 1'b1, 8'h11);
    vecs[8]  = mk(2'b11, 1'b1, 17'h0,           9'h012, 8'h22, 1, 1, 9'h011, 1'b0, 8'h00);
    vecs[9]  = mk(2'b10, 1'b0, {9'h000, 8'h33}, 9'h012, 8'h33, 0, 0, 9'h000, 1'b1, 8'h22);
    vecs[10] = mk(2'b11, 1'b1, 17'h0,           9'h013, 8'h33, 1, 1, 9'h012, 1'b0, 8'h00);
    vecs[11] = mk(2'b10, 1'b0, {9'h000, 8'h44}, 9'h013, 8'h44, 0, 0, 9'h000, 1'b1, 8'h33);
    vecs[12] = mk(2'b11, 1'b1, 17'h0,           9'h014, 8'h44, 1, 1, 9'h013, 1'b0, 8'h00);
    vecs[13] = mk(2'b00, 1'b0, {9'h1FF, 8'h5A}, 9'h1FF, 8'h5A, 0, 0, 9'h000, 1'b1, 8'h44);
    vecs[14] = mk(2'b11, 1'b1, 17'h0,           9'h000, 8'h5A, 1, 1, 9'h1FF, 1'b0, 8'h00);
    vecs[15] = mk(2'b00, 1'b0, {9'h010, 8'h00}, 9'h010, 8'h00, 0, 0, 9'h000, 1'b1, 8'h5A);
    vecs[16] = mk(2'b01, 1'b1, 17'h0,           9'h011, 8'h11, 1, 0, 9'h000, 1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_rdy", rdy, 1'b0);
    check("reset_cen", cen, 1'b1);
    check("reset_we", d_we, 1'b1);
    check("reset_a", a, 9'h000);
    check("reset_po", po, 8'h00);
    check("reset_so", so, 1'b0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a write cycle
    v = mk(2'b00, 1'b0, {9'h0AB, 8'h77}, 9'h0AB, 8'h77, 0, 0, 9'h000, 1'b0, 8'h00);
    run_op(v, 100);
    @(negedge clk);
    ctrl = 2'b11; auto_inc = 1'b0; bgn = 1'b1; load_n = 1'b0;
    @(posedge clk);
    #2;
    check("rst_pre_cen", cen, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_cen", cen, 1'b1);
    check("rst_async_we", d_we, 1'b1);
    check("rst_async_rdy", rdy, 1'b0);
    @(negedge clk);
    bgn = 1'b0; load_n = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_a", a, 9'h000);
    check("rst_after_po", po, 8'h00);
    check("rst_no_write", mem[9'h0AB], 8'h00);

    // Table: write/read-back, burst with auto-increment, wrap, burst read-back
    for (int i = 0; i < 17; i++) run_op(vecs[i], i);
    check("mem_10", mem[9'h010], 8'h11);
    check("mem_11", mem[9'h011], 8'h22);
    check("mem_12", mem[9'h012], 8'h33);
    check("mem_13", mem[9'h013], 8'h44);
    check("mem_1ff", mem[9'h1FF], 8'h5A);
    check("mem_020", mem[9'h020], 8'h3C);

    // Handshake: BGN held after RDY gives no second access
    @(negedge clk);
    ctrl = 2'b11; auto_inc = 1'b0; bgn = 1'b1; load_n = 1'b0;
    acc = 0;
    for (int t = 0; t < 10 && !rdy; t++) begin
      @(negedge clk);
      if (!cen) acc++;
    end
    check("hold_rdy_seen", rdy, 1'b1);
    check("hold_first_access", acc, 1);
    bad = 0; acc = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!rdy) bad++;
      if (!cen) acc++;
    end
    check("hold_rdy_stuck", bad, 0);
    check("hold_no_access", acc, 0);
    bgn = 1'b0;
    @(negedge clk);
    check("hold_rdy_drop", rdy, 1'b0);
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (!cen || rdy) bad++;
    end
    check("no_relaunch_load_low", bad, 0);
    check("hold_a", a, 9'h011);
    load_n = 1'b1;

    // BGN dropped during a data shift: shift completes, RDY pulses once
    @(negedge clk);
    ctrl = 2'b10; bgn = 1'b1; load_n = 1'b0; p = 8'hA5;
    @(negedge clk);
    load_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      si = p[k];
      if (k == 2) bgn = 1'b0;
      if (rdy) bad++;
      @(negedge clk);
    end
    check("drop_early_rdy", bad, 0);
    check("drop_rdy_pulse", rdy, 1'b1);
    check("drop_po", po, 8'hA5);
    check("drop_a", a, 9'h011);
    @(negedge clk);
    check("drop_rdy_end", rdy, 1'b0);

    // Read latency 3: capture value the SRAM presents 3 edges after the CEN-low edge
    @(negedge clk);
    ctrl = 2'b01; auto_inc = 1'b0; bgn3 = 1'b1; load_n = 1'b0;
    @(negedge clk);
    load_n = 1'b1;
    p = 8'h00; acc = 0;
    for (int t = 0; t < 12 && !rdy3; t++) begin
      if (!cen3) begin acc++; p = pi3; end
      @(negedge clk);
    end
    check("lat3_rdy", rdy3, 1'b1);
    check("lat3_cen_cycles", acc, 1);
    check("lat3_capture", po3, p + 8'd3);
    check("main_idle_during_lat3", rdy, 1'b0);
    bgn3 = 1'b0;
    @(negedge clk);
    check("lat3_rdy_drop", rdy3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
